vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, front-porch clocks.
REQ-003 Parameter H_SYNC, 96, hsync pulse clocks.
REQ-004 Parameter H_BACK, 48, back-porch clocks. H_BLANK = H_FRONT+H_SYNC+H_BACK (160); H_TOTAL = H_BLANK+H_ACTIVE (800).
REQ-005 Parameter V_ACTIVE, 480, visible lines.
REQ-006 Parameter V_FRONT, 10, front-porch lines.
REQ-007 Parameter V_SYNC, 2, vsync lines.
REQ-008 Parameter V_BACK, 33, back-porch lines. V_BLANK = 45; V_TOTAL = 525.
REQ-009 clk  input  1  pixel clock, one pixel per cycle; sole clock.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 pixel_in  input  1  pixel bit from video RAM stage for current display_hpos/display_vpos.
REQ-012 test_pattern  input  1  selects internal pattern (only with VGA_TEST_PATTERN_EN).
REQ-013 display_active  output  1  current position visible.
REQ-014 display_hpos  output  10  horizontal active coordinate.
REQ-015 display_vpos  output  10  vertical active coordinate.
REQ-016 clks_before_active  output  10  clocks until line's first active pixel.
REQ-017 frame_start  output  1  one-cycle pulse at h_count=0, v_count=0.
REQ-018 vga_hsync  output  1  registered hsync, active-low.
REQ-019 vga_vsync  output  1  registered vsync, active-low.
REQ-020 vga_pixel  output  1  registered pixel, 0 when blanked.

Function
REQ-021 Internal h_count 0..H_TOTAL-1 increments each clk; wraps to 0 after H_TOTAL-1 and increments v_count.
REQ-022 v_count 0..V_TOTAL-1; wraps to 0 when both counters are at their maximum values in the same cycle.
REQ-023 Line order: front porch [0,H_FRONT), sync [H_FRONT,H_FRONT+H_SYNC), back porch, active [H_BLANK,H_TOTAL); vertical uses the same order in lines.
REQ-024 display_active = (h_count>=H_BLANK) && (v_count>=V_BLANK), combinational from counters.
REQ-025 display_hpos = h_count-H_BLANK when h_count>=H_BLANK, else 10'h3FF.
REQ-026 display_vpos = v_count-V_BLANK when v_count>=V_BLANK, else 10'h3FF; valid during the whole line, blanking included.
REQ-027 clks_before_active = H_BLANK-h_count when h_count<H_BLANK, else 0; equals 42 at h_count=118 on every line.
REQ-028 frame_start high exactly one cycle per frame.
REQ-029 Sync raw = active-low during sync window; vga_hsync/vga_vsync registered from counter state of the previous cycle.
REQ-030 vga_pixel <= display_active ? pixel_in : 0, registered; latency 1 clk, aligned with syncs.
REQ-031 Counter widths 10 bits; no counter exceeds H_TOTAL-1 / V_TOTAL-1 in any cycle.

Reset
REQ-032 On reset assertion, asynchronously: h_count=0, v_count=0, vga_hsync=1, vga_vsync=1, vga_pixel=0.
REQ-033 Combinational outputs follow reset counters: display_active=0, display_hpos=3FF, display_vpos=3FF, clks_before_active=160, frame_start=1.
REQ-034 After reset deassertion, first clk edge advances h_count to 1; reset mid-frame restarts at frame origin.

Configuration
REQ-035 Macro VGA_TEST_PATTERN_EN: when defined and test_pattern=1, vga_pixel during active = display_hpos[4]^display_vpos[4] instead of pixel_in.
REQ-036 Without VGA_TEST_PATTERN_EN, test_pattern is ignored and vga_pixel always sources pixel_in.

Verification
REQ-037 Reset then 800*525 clks -> exactly one frame_start pulse, at cycle 0 and again at cycle 420000.
REQ-038 Count per line -> vga_hsync low for 96 consecutive clks starting one clk after h_count=16; vga_vsync low for 2 lines (1600 clks) starting after line 10.
REQ-039 Line 45, h_count 118 -> clks_before_active=42, display_vpos=0; h_count 160 -> display_hpos=0, display_active=1.
REQ-040 pixel_in tied 1 -> vga_pixel=1 for 640x480 pixels per frame, 0 elsewhere, lagging display_active by 1 clk.
REQ-041 Assert reset at h_count=300, v_count=200 -> immediate vga_hsync=vga_vsync=1, vga_pixel=0; after release counters resume from 0,0.
REQ-042 VGA_TEST_PATTERN_EN defined, test_pattern=1, pixel_in=0 -> vga_pixel=1 at display_hpos=16, display_vpos=0; vga_pixel=0 at display_hpos=16, display_vpos=16.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the VGA timing generator (master) and its pixel source / display sink (slave).
interface vga_timing_gen_if;
  logic       pixel_in;
  logic       test_pattern;
  logic       display_active;
  logic [9:0] display_hpos;
  logic [9:0] display_vpos;
  logic [9:0] clks_before_active;
  logic       frame_start;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_pixel;

  modport master (
    input  pixel_in, test_pattern,
    output display_active, display_hpos, display_vpos, clks_before_active,
           frame_start, vga_hsync, vga_vsync, vga_pixel
  );

  modport slave (
    output pixel_in, test_pattern,
    input  display_active, display_hpos, display_vpos, clks_before_active,
           frame_start, vga_hsync, vga_vsync, vga_pixel
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: blanking-first line/frame counters, registered active-low syncs and pixel.
// Optional build macro VGA_TEST_PATTERN_EN adds an internal checkerboard selected by test_pattern.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam logic [9:0] H_BLANK    = 10'(H_FRONT + H_SYNC + H_BACK);
  localparam logic [9:0] H_MAX      = 10'(H_FRONT + H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_FRONT + H_SYNC);
  localparam logic [9:0] V_BLANK    = 10'(V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0] V_MAX      = 10'(V_FRONT + V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_FRONT + V_SYNC);

  logic [9:0] r_h_count;
  logic [9:0] r_v_count;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_pixel;

  logic       w_h_active;
  logic       w_v_active;
  logic       w_active;
  logic [9:0] w_hpos;
  logic [9:0] w_vpos;
  logic       w_hsync_raw;
  logic       w_vsync_raw;
  logic       w_pixel_src;

  // NOTE: state uses non-blocking assignments so every register samples the pre-edge counter values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (r_h_count == H_MAX) begin
      r_h_count <= '0;
      r_v_count <= (r_v_count == V_MAX) ? '0 : r_v_count + 10'd1;
    end else begin
      r_h_count <= r_h_count + 10'd1;
    end
  end

  assign w_h_active  = (r_h_count >= H_BLANK);
  assign w_v_active  = (r_v_count >= V_BLANK);
  assign w_active    = w_h_active && w_v_active;
  assign w_hpos      = w_h_active ? r_h_count - H_BLANK : 10'h3FF;
  assign w_vpos      = w_v_active ? r_v_count - V_BLANK : 10'h3FF;
  assign w_hsync_raw = !((r_h_count >= H_SYNC_BEG) && (r_h_count < H_SYNC_END));
  assign w_vsync_raw = !((r_v_count >= V_SYNC_BEG) && (r_v_count < V_SYNC_END));

`ifdef VGA_TEST_PATTERN_EN
  assign w_pixel_src = vga.test_pattern ? (w_hpos[4] ^ w_vpos[4]) : vga.pixel_in;
`else
  logic w_unused_test_pattern;
  assign w_unused_test_pattern = vga.test_pattern;
  assign w_pixel_src           = vga.pixel_in;
`endif

  // Syncs and pixel share one register stage so they stay aligned at the connector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_pixel <= 1'b0;
    end else begin
      r_hsync <= w_hsync_raw;
      r_vsync <= w_vsync_raw;
      r_pixel <= w_active ? w_pixel_src : 1'b0;
    end
  end

  assign vga.display_active     = w_active;
  assign vga.display_hpos       = w_hpos;
  assign vga.display_vpos       = w_vpos;
  assign vga.clks_before_active = w_h_active ? 10'd0 : H_BLANK - r_h_count;
  assign vga.frame_start        = (r_h_count == 10'd0) && (r_v_count == 10'd0);
  assign vga.vga_hsync          = r_hsync;
  assign vga.vga_vsync          = r_vsync;
  assign vga.vga_pixel          = r_pixel;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a scaled-down instance and a default 640x480 instance checked every cycle
// against a raster model computed from the position index (cycles since reset release).
module tb_vga_timing_gen;

  typedef struct {
    int hf, hs, hb, ha, vf, vs, vb, va;
  } tim_t;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_b;
  int   tests;
  int   fails;

  vga_timing_gen_if if_s ();
  vga_timing_gen_if if_b ();

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_ACTIVE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_s (
    .clk  (clk),
    .reset(rst_s),
    .vga  (if_s)
  );

  vga_timing_gen dut_b (
    .clk  (clk),
    .reset(rst_b),
    .vga  (if_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs from the raster position reached n clocks after reset release;
  // pin/tp are the inputs the DUT sampled on the most recent edge.
  task automatic model_check(input string tag, input tim_t p, input int n, input bit pin, input bit tp,
                             input logic act, input logic [9:0] hpos, input logic [9:0] vpos,
                             input logic [9:0] cba, input logic fs, input logic hs, input logic vs,
                             input logic pix);
    int hbl, htot, vbl, vtot, h, v, ph, pv;
    bit e_hs, e_vs, e_pix, src;
    hbl  = p.hf + p.hs + p.hb;
    htot = hbl + p.ha;
    vbl  = p.vf + p.vs + p.vb;
    vtot = vbl + p.va;
    h    = n % htot;
    v    = (n / htot) % vtot;
    check($sformatf("%s active n=%0d", tag, n), 32'(act), 32'(h >= hbl && v >= vbl));
    check($sformatf("%s hpos n=%0d", tag, n), 32'(hpos), (h >= hbl) ? h - hbl : 1023);
    check($sformatf("%s vpos n=%0d", tag, n), 32'(vpos), (v >= vbl) ? v - vbl : 1023);
    check($sformatf("%s clks_before_active n=%0d", tag, n), 32'(cba), (h < hbl) ? hbl - h : 0);
    check($sformatf("%s frame_start n=%0d", tag, n), 32'(fs), 32'(h == 0 && v == 0));
    if (n == 0) begin
      e_hs  = 1'b1;
      e_vs  = 1'b1;
      e_pix = 1'b0;
    end else begin
      ph   = (n - 1) % htot;
      pv   = ((n - 1) / htot) % vtot;
      e_hs = !(ph >= p.hf && ph < p.hf + p.hs);
      e_vs = !(pv >= p.vf && pv < p.vf + p.vs);
      src  = pin;
`ifdef VGA_TEST_PATTERN_EN
      if (tp && ph >= hbl && pv >= vbl) src = 1'(((ph - hbl) >> 4) ^ ((pv - vbl) >> 4));
`else
      if (tp) src = pin;
`endif
      e_pix = (ph >= hbl && pv >= vbl) ? src : 1'b0;
    end
    check($sformatf("%s hsync n=%0d", tag, n), 32'(hs), 32'(e_hs));
    check($sformatf("%s vsync n=%0d", tag, n), 32'(vs), 32'(e_vs));
    check($sformatf("%s pixel n=%0d", tag, n), 32'(pix), 32'(e_pix));
  endtask

  task automatic check_small(input int n, input bit pin, input bit tp);
    tim_t p;
    p = '{hf: 3, hs: 5, hb: 4, ha: 20, vf: 2, vs: 2, vb: 3, va: 20};
    model_check("small", p, n, pin, tp, if_s.display_active, if_s.display_hpos, if_s.display_vpos,
                if_s.clks_before_active, if_s.frame_start, if_s.vga_hsync, if_s.vga_vsync,
                if_s.vga_pixel);
  endtask

  task automatic check_big(input int n, input bit pin, input bit tp);
    tim_t p;
    p = '{hf: 16, hs: 96, hb: 48, ha: 640, vf: 10, vs: 2, vb: 33, va: 480};
    model_check("big", p, n, pin, tp, if_b.display_active, if_b.display_hpos, if_b.display_vpos,
                if_b.clks_before_active, if_b.frame_start, if_b.vga_hsync, if_b.vga_vsync,
                if_b.vga_pixel);
  endtask

  initial begin
    int n_s, n_b;
    bit did_rst;
    tests   = 0;
    fails   = 0;
    n_s     = 0;
    n_b     = 0;
    did_rst = 1'b0;
    rst_s   = 1'b1;
    rst_b   = 1'b1;
    if_s.pixel_in     = 1'b0;
    if_s.test_pattern = 1'b0;
    if_b.pixel_in     = 1'b1;
    if_b.test_pattern = 1'b0;

    repeat (3) @(negedge clk);
    check_small(0, 1'b0, 1'b0);
    check_big(0, 1'b1, 1'b0);
    check("big reset clks_before_active", 32'(if_b.clks_before_active), 160);
    check("big reset frame_start", 32'(if_b.frame_start), 1);
    check("big reset hpos", 32'(if_b.display_hpos), 32'h3FF);
    rst_s = 1'b0;
    rst_b = 1'b0;

    while (n_b < 36200) begin
      @(posedge clk);
      if (!rst_s) n_s++;
      n_b++;
      @(negedge clk);
      check_small(n_s, if_s.pixel_in, if_s.test_pattern);
      check_big(n_b, if_b.pixel_in, if_b.test_pattern);

      // Hand-computed anchors for the default 640x480 timing.
      if (n_b == 16)    check("big hsync before pulse", 32'(if_b.vga_hsync), 1);
      if (n_b == 17)    check("big hsync first low", 32'(if_b.vga_hsync), 0);
      if (n_b == 112)   check("big hsync last low", 32'(if_b.vga_hsync), 0);
      if (n_b == 113)   check("big hsync released", 32'(if_b.vga_hsync), 1);
      if (n_b == 8000)  check("big vsync before pulse", 32'(if_b.vga_vsync), 1);
      if (n_b == 8001)  check("big vsync first low", 32'(if_b.vga_vsync), 0);
      if (n_b == 9600)  check("big vsync last low", 32'(if_b.vga_vsync), 0);
      if (n_b == 9601)  check("big vsync released", 32'(if_b.vga_vsync), 1);
      if (n_b == 36118) begin
        check("big line45 clks_before_active", 32'(if_b.clks_before_active), 42);
        check("big line45 vpos", 32'(if_b.display_vpos), 0);
      end
      if (n_b == 36160) begin
        check("big line45 hpos", 32'(if_b.display_hpos), 0);
        check("big line45 active", 32'(if_b.display_active), 1);
      end
      if (n_s == 864 && did_rst) check("small second frame_start", 32'(if_s.frame_start), 1);

      if (rst_s) begin
        rst_s = 1'b0;
      end else if (!did_rst && n_s == 965) begin
        // Both syncs are low here (line 3, clock 4), so the async clear is observable.
        check("small pre-reset hsync", 32'(if_s.vga_hsync), 0);
        check("small pre-reset vsync", 32'(if_s.vga_vsync), 0);
        rst_s = 1'b1;
        #1;
        n_s     = 0;
        did_rst = 1'b1;
        check_small(0, 1'b0, 1'b0);
      end

      if_s.pixel_in     = 1'($urandom);
      if_s.test_pattern = 1'($urandom);
      if_b.pixel_in     = ($urandom_range(0, 7) != 0);
      if_b.test_pattern = 1'($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
